// File: rtl/pacman_life_manager.sv
// pacman_life_manager
//   Game-flow sequencer fed by collision_detection. Runs the life cycle
//   (play, death animation, respawn, game over) and drives the movement
//   freeze, the one-cycle sprite respawn pulse, the death-animation frame
//   index and the HUD lives count. Frame timing comes from frame_tick, a
//   one-cycle pulse issued once per video frame.
//
//   Optional feature: macro PACMAN_INVULN_EN adds parameter INVULN_FRAMES
//   and output invulnerable. The flag is high for the first INVULN_FRAMES
//   frame_ticks after each PLAYING entry, and collisions are ignored while
//   it is high.
//
// Ports
//   clka             in   system clock, rising edge
//   resetn           in   asynchronous active-low reset
//   frame_tick       in   one-cycle pulse per video frame
//   start_game       in   one-cycle start pulse (debounced button)
//   pacman_is_dead   in   collision level from collision_detection
//   lives_left       out  remaining lives (LIVES_W bits)
//   freeze           out  1 = sprite movement must hold position
//   respawn          out  one-cycle pulse, sprites reload start positions
//   death_anim_frame out  renderer frame index while DYING, else 0
//   game_over        out  high while in GAME_OVER
//   game_state       out  IDLE=0 PLAYING=1 DYING=2 RESPAWN=3 GAME_OVER=4
//   invulnerable     out  (PACMAN_INVULN_EN only) collision immunity flag
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | after reset; frozen, waiting for start_game
// PLAYING    | sprites move; a collision costs a life
// DYING      | death animation, DEATH_FRAMES ticks, frame index output
// RESPAWN    | frozen pause, RESPAWN_FRAMES ticks, then back to PLAYING
// GAME_OVER  | no lives left; start_game restarts with full lives
module pacman_life_manager #(
  parameter int INIT_LIVES     = 3,
  parameter int LIVES_W        = 2,
  parameter int DEATH_FRAMES   = 12,
  parameter int RESPAWN_FRAMES = 60,
  parameter int CNT_W          = 7
`ifdef PACMAN_INVULN_EN
  ,
  parameter int INVULN_FRAMES  = 90
`endif
) (
  input  logic               clka,
  input  logic               resetn,
  input  logic               frame_tick,
  input  logic               start_game,
  input  logic               pacman_is_dead,
  output logic [LIVES_W-1:0] lives_left,
  output logic               freeze,
  output logic               respawn,
  output logic [3:0]         death_anim_frame,
  output logic               game_over,
  output logic [2:0]         game_state
`ifdef PACMAN_INVULN_EN
  ,
  output logic               invulnerable
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLAYING   = 3'd1,
    ST_DYING     = 3'd2,
    ST_RESPAWN   = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0]   DEATH_LAST   = CNT_W'(DEATH_FRAMES - 1);
  localparam logic [CNT_W-1:0]   RESPAWN_LAST = CNT_W'(RESPAWN_FRAMES - 1);
  localparam logic [LIVES_W-1:0] LIVES_INIT   = LIVES_W'(INIT_LIVES);

  state_t             state;
  logic [CNT_W-1:0]   counter;
  logic [CNT_W-1:0]   cnt_inc;
  logic               ignore_hit;

  assign cnt_inc    = counter + 1'b1;
  assign game_state = state;

`ifdef PACMAN_INVULN_EN
  localparam int               INV_W    = (INVULN_FRAMES > 1) ? $clog2(INVULN_FRAMES + 1) : 1;
  localparam logic [INV_W-1:0] INV_LAST = INV_W'(INVULN_FRAMES - 1);

  logic [INV_W-1:0] inv_cnt;
  logic             play_entry;

  // Every edge on which the FSM moves into PLAYING restarts the immunity
  // window; a tick on that same edge is not counted.
  assign play_entry = ((state == ST_IDLE || state == ST_GAME_OVER) && start_game) ||
                      (state == ST_RESPAWN && frame_tick && counter == RESPAWN_LAST);
  assign ignore_hit = invulnerable;

  always_ff @(posedge clka or negedge resetn) begin
    if (!resetn) begin
      invulnerable <= 1'b0;
      inv_cnt      <= '0;
    end else if (play_entry) begin
      invulnerable <= (INVULN_FRAMES > 0);
      inv_cnt      <= '0;
    end else if (state != ST_PLAYING) begin
      invulnerable <= 1'b0;
      inv_cnt      <= '0;
    end else if (invulnerable && frame_tick) begin
      if (inv_cnt == INV_LAST) begin
        invulnerable <= 1'b0;
      end else begin
        inv_cnt <= inv_cnt + 1'b1;
      end
    end
  end
`else
  assign ignore_hit = 1'b0;
`endif

  always_ff @(posedge clka or negedge resetn) begin
    if (!resetn) begin
      state            <= ST_IDLE;
      lives_left       <= LIVES_INIT;
      freeze           <= 1'b1;
      respawn          <= 1'b0;
      death_anim_frame <= 4'd0;
      game_over        <= 1'b0;
      counter          <= '0;
    end else begin
      respawn <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_game) begin
            state      <= ST_PLAYING;
            freeze     <= 1'b0;
            lives_left <= LIVES_INIT;
            respawn    <= 1'b1;
          end
        end

        ST_PLAYING: begin
          // A coincident frame_tick has no meaning here and is dropped.
          if (pacman_is_dead && !ignore_hit) begin
            state            <= ST_DYING;
            freeze           <= 1'b1;
            lives_left       <= (lives_left == '0) ? '0 : lives_left - 1'b1;
            counter          <= '0;
            death_anim_frame <= 4'd0;
          end
        end

        ST_DYING: begin
          if (frame_tick) begin
            if (counter == DEATH_LAST) begin
              counter          <= '0;
              death_anim_frame <= 4'd0;
              if (lives_left == '0) begin
                state     <= ST_GAME_OVER;
                game_over <= 1'b1;
              end else begin
                state   <= ST_RESPAWN;
                respawn <= 1'b1;
              end
            end else begin
              counter          <= cnt_inc;
              // low nibble only; animations longer than 16 frames wrap
              death_anim_frame <= cnt_inc[3:0];
            end
          end
        end

        ST_RESPAWN: begin
          if (frame_tick) begin
            if (counter == RESPAWN_LAST) begin
              state   <= ST_PLAYING;
              freeze  <= 1'b0;
              counter <= '0;
            end else begin
              counter <= cnt_inc;
            end
          end
        end

        ST_GAME_OVER: begin
          if (start_game) begin
            state      <= ST_PLAYING;
            freeze     <= 1'b0;
            game_over  <= 1'b0;
            lives_left <= LIVES_INIT;
            respawn    <= 1'b1;
          end
        end

        default: begin
          state            <= ST_IDLE;
          freeze           <= 1'b1;
          game_over        <= 1'b0;
          death_anim_frame <= 4'd0;
          counter          <= '0;
        end
      endcase
    end
  end

endmodule
